// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared constants and types for the writeback arbiter slice.
//   ZeroWord / ZeroReg  : all-zero data word and the x0 register address
//   RegAddrWidth        : register file address width
//   WbDepthDefault      : default load-result FIFO depth
//   wb_entry_t          : one buffered load result {waddr, wdata}
//   wb_src_e            : which source drives the output write register this cycle
package wb_arbiter_pkg;

    localparam int unsigned RegAddrWidth   = 5;
    localparam int unsigned RegDataWidth   = 32;
    localparam int unsigned WbDepthDefault = 4;
    localparam int unsigned WbEntryWidth   = RegAddrWidth + RegDataWidth;

    localparam logic [RegDataWidth-1:0] ZeroWord = '0;
    localparam logic [RegAddrWidth-1:0] ZeroReg  = '0;

    typedef struct packed {
        logic [RegAddrWidth-1:0] waddr;
        logic [RegDataWidth-1:0] wdata;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SrcNone,
        SrcEx,
        SrcFifo,
        SrcLsu
    } wb_src_e;

    // A write only counts when it targets a real register; x0 writes vanish at the source.
    function automatic logic wb_live(input logic valid, input logic [RegAddrWidth-1:0] addr);
        return valid && (addr != ZeroReg);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of packed {waddr, wdata} load results.
//   DEPTH    : number of entries (power of two, >= 2)
//   clk, rst : rising-edge clock, asynchronous active-high reset (empties the FIFO)
//   push_i   : write din_i; honoured when not full, or when full and popping the same cycle
//   din_i    : entry to write
//   pop_i    : drop the head entry; ignored when empty
//   dout_o   : head entry (meaningful only when !empty_o)
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WbDepthDefault
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic [WbEntryWidth-1:0] din_i,
    input  logic                    pop_i,
    output logic [WbEntryWidth-1:0] dout_o,
    output logic                    full_o,
    output logic                    empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    logic [WbEntryWidth-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [CntW-1:0]         count_q;
    logic                    do_push;
    logic                    do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still take a push when the head leaves on the same edge.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter and load scoreboard driving the register file write port.
//   Merges single-cycle EX results with buffered long-latency load results into one
//   registered write port, and keeps a busy bit per register with a load in flight.
//   DEPTH                    : load-result FIFO entries (power of two, >= 2)
//   clk, rst                 : rising-edge clock, asynchronous active-high reset
//   ex_wen_i/waddr_i/wdata_i : EX result; ex_stall_o tells EX to hold it this cycle
//   lsu_valid_i/ready_o      : load-result handshake, lsu_waddr_i/lsu_wdata_i payload
//   issue_valid_i/waddr_i    : ID issues a load, marking its rd busy
//   rs1/rs2/rd_addr_i        : ID lookup addresses; *_busy_o report a pending load
//   reg_waddr_o/wdata_o/wen_o: registered write port to regs
// Build option WB_LSU_BYPASS_EN: a load arriving while the FIFO is empty and EX is idle is
// written straight into the output register, skipping the FIFO.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WbDepthDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_wen_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        ex_stall_o,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_waddr_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        rd_busy_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        reg_wen_o
);

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [WbEntryWidth-1:0] fifo_dout;
    wb_entry_t               fifo_head;

    logic                    ex_live;
    logic                    lsu_live;
    wb_src_e                 src;

    logic                    clr_en;
    logic [4:0]              clr_addr;
    logic [31:0]             busy_q;
    logic [31:0]             busy_d;

    // Full comes from the FIFO's registered count, so EX never sees a combinational stall.
    assign ex_stall_o  = fifo_full;
    assign lsu_ready_o = !fifo_full && !rst;

    assign ex_live   = wb_live(ex_wen_i, ex_waddr_i);
    // Loads to x0 complete the handshake but are never stored.
    assign lsu_live  = wb_live(lsu_valid_i && lsu_ready_o, lsu_waddr_i);
    assign fifo_head = wb_entry_t'(fifo_dout);

    // Source select: a full FIFO must drain first, otherwise EX has priority over loads.
    always_comb begin
        src = SrcNone;
        if (fifo_full) begin
            src = SrcFifo;
        end else if (ex_live) begin
            src = SrcEx;
        end else if (!fifo_empty) begin
            src = SrcFifo;
        end
`ifdef WB_LSU_BYPASS_EN
        else if (lsu_live) begin
            src = SrcLsu;
        end
`endif
    end

    assign fifo_pop  = (src == SrcFifo);
    assign fifo_push = lsu_live && (src != SrcLsu);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   ({lsu_waddr_i, lsu_wdata_i}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Registered write port; address/data hold their last value while wen is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= ZeroReg;
            reg_wdata_o <= ZeroWord;
        end else begin
            case (src)
                SrcEx: begin
                    reg_wen_o   <= 1'b1;
                    reg_waddr_o <= ex_waddr_i;
                    reg_wdata_o <= ex_wdata_i;
                end
                SrcFifo: begin
                    reg_wen_o   <= 1'b1;
                    reg_waddr_o <= fifo_head.waddr;
                    reg_wdata_o <= fifo_head.wdata;
                end
                SrcLsu: begin
                    reg_wen_o   <= 1'b1;
                    reg_waddr_o <= lsu_waddr_i;
                    reg_wdata_o <= lsu_wdata_i;
                end
                default: begin
                    reg_wen_o   <= 1'b0;
                end
            endcase
        end
    end

    // A load result entering the output register retires its destination's busy bit.
    assign clr_en   = (src == SrcFifo) || (src == SrcLsu);
    assign clr_addr = (src == SrcLsu) ? lsu_waddr_i : fifo_head.waddr;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        // Applied after the clear so a fresh issue to the same register stays pending.
        if (wb_live(issue_valid_i, issue_waddr_i)) begin
            busy_d[issue_waddr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];
    assign rd_busy_o  = busy_q[rd_addr_i];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based model of the writeback rules is compared
// against the DUT on every negative clock edge, and directed scenarios add literal checks.
module tb_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_wen_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_stall_o;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        issue_valid_i;
    logic [4:0]  issue_waddr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [4:0]  rd_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        rd_busy_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        reg_wen_o;

    wb_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_wen_i      (ex_wen_i),
        .ex_waddr_i    (ex_waddr_i),
        .ex_wdata_i    (ex_wdata_i),
        .ex_stall_o    (ex_stall_o),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_waddr_i   (lsu_waddr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .issue_valid_i (issue_valid_i),
        .issue_waddr_i (issue_waddr_i),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rd_addr_i     (rd_addr_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
        .rd_busy_o     (rd_busy_o),
        .reg_waddr_o   (reg_waddr_o),
        .reg_wdata_o   (reg_wdata_o),
        .reg_wen_o     (reg_wen_o)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    bit          m_busy[32];
    bit          m_wen = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    bit          m_full;
    bit          m_acc;
    bit          m_byp;
    bit          m_ex;
    ent_t        m_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_wen = 1'b0;
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            m_full = (q.size() == DEPTH);
            m_ex   = ex_wen_i && (ex_waddr_i != 5'd0);
            m_acc  = lsu_valid_i && !m_full && (lsu_waddr_i != 5'd0);
            m_byp  = 1'b0;
            m_wen  = 1'b0;
            if (m_full || (!m_ex && q.size() != 0)) begin
                m_e     = q.pop_front();
                m_wen   = 1'b1;
                m_waddr = m_e.a;
                m_wdata = m_e.d;
                m_busy[m_e.a] = 1'b0;
            end else if (m_ex) begin
                m_wen   = 1'b1;
                m_waddr = ex_waddr_i;
                m_wdata = ex_wdata_i;
            end
`ifdef WB_LSU_BYPASS_EN
            else if (m_acc) begin
                m_wen   = 1'b1;
                m_waddr = lsu_waddr_i;
                m_wdata = lsu_wdata_i;
                m_byp   = 1'b1;
                m_busy[lsu_waddr_i] = 1'b0;
            end
`endif
            if (m_acc && !m_byp) q.push_back('{a: lsu_waddr_i, d: lsu_wdata_i});
            if (issue_valid_i && issue_waddr_i != 5'd0) m_busy[issue_waddr_i] = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("reg_wen", reg_wen_o, m_wen);
            if (m_wen) begin
                chk("reg_waddr", reg_waddr_o, m_waddr);
                chk("reg_wdata", reg_wdata_o, m_wdata);
            end
            chk("ex_stall", ex_stall_o, q.size() == DEPTH);
            chk("lsu_ready", lsu_ready_o, (q.size() != DEPTH) && !rst);
            chk("rs1_busy", rs1_busy_o, m_busy[rs1_addr_i]);
            chk("rs2_busy", rs2_busy_o, m_busy[rs2_addr_i]);
            chk("rd_busy", rd_busy_o, m_busy[rd_addr_i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_wen_i      = 1'b0;
        ex_waddr_i    = '0;
        ex_wdata_i    = '0;
        lsu_valid_i   = 1'b0;
        lsu_waddr_i   = '0;
        lsu_wdata_i   = '0;
        issue_valid_i = 1'b0;
        issue_waddr_i = '0;
    endtask

    int ex_i;
    int ld_i;
    int stalls;
    int wens;

    initial begin
        rst = 1'b1;
        idle();
        rs1_addr_i = '0;
        rs2_addr_i = '0;
        rd_addr_i  = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_wen", reg_wen_o, 0);
        chk("rst_waddr", reg_waddr_o, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_ready", lsu_ready_o, 0);
        chk("rst_stall", ex_stall_o, 0);
        chk("rst_busy", rs1_busy_o, 0);
        started = 1'b1;
        rst = 1'b0;
        tick();

        // EX only
        ex_wen_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234;
        tick();
        idle();
        #2;
        chk("ex_wen", reg_wen_o, 1);
        chk("ex_waddr", reg_waddr_o, 5);
        chk("ex_wdata", reg_wdata_o, 32'h1234);
        ex_wen_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hAAAA;
        tick();
        idle();
        #2;
        chk("ex_x0_wen", reg_wen_o, 0);
        tick();

        // Load path: issue rd=7, then load accepted one cycle later
        issue_valid_i = 1'b1; issue_waddr_i = 5'd7; rs1_addr_i = 5'd7;
        tick();
        idle();
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd7; lsu_wdata_i = 32'hDEADBEEF;
        #2;
        chk("ld_busy_acc", rs1_busy_o, 1);
        chk("ld_ready", lsu_ready_o, 1);
        tick();
        idle();
        #2;
`ifdef WB_LSU_BYPASS_EN
        chk("ld_n1_wen", reg_wen_o, 1);
        chk("ld_n1_waddr", reg_waddr_o, 7);
        chk("ld_n1_wdata", reg_wdata_o, 32'hDEADBEEF);
        chk("ld_n1_busy", rs1_busy_o, 0);
`else
        chk("ld_n1_wen", reg_wen_o, 0);
        chk("ld_n1_busy", rs1_busy_o, 1);
`endif
        tick();
        #2;
`ifdef WB_LSU_BYPASS_EN
        chk("ld_n2_wen", reg_wen_o, 0);
`else
        chk("ld_n2_wen", reg_wen_o, 1);
        chk("ld_n2_waddr", reg_waddr_o, 7);
        chk("ld_n2_wdata", reg_wdata_o, 32'hDEADBEEF);
`endif
        chk("ld_n2_busy", rs1_busy_o, 0);
        tick();

        // Load to x0: accepted, never written
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd0; lsu_wdata_i = 32'h55;
        #2;
        chk("ld_x0_ready", lsu_ready_o, 1);
        tick();
        idle();
        #2;
        chk("ld_x0_wen_a", reg_wen_o, 0);
        tick();
        #2;
        chk("ld_x0_wen_b", reg_wen_o, 0);
        tick();

        // Contention: EX every cycle while DEPTH loads arrive
        rs1_addr_i = 5'd10; rs2_addr_i = 5'd13; rd_addr_i = 5'd11;
        for (int i = 0; i < 4; i++) begin
            issue_valid_i = 1'b1; issue_waddr_i = 5'(10 + i);
            tick();
        end
        idle();
        ex_i = 0; ld_i = 0; stalls = 0;
        for (int c = 0; c < 40 && ex_i < 10; c++) begin
            ex_wen_i    = 1'b1;
            ex_waddr_i  = 5'(20 + ex_i);
            ex_wdata_i  = 32'h1000 + 32'(ex_i);
            lsu_valid_i = (ld_i < 4);
            lsu_waddr_i = 5'(10 + ld_i);
            lsu_wdata_i = 32'hC0DE0000 + 32'(ld_i);
            #2;
            if (ex_stall_o) stalls++;
            else ex_i++;
            if (lsu_valid_i && lsu_ready_o) ld_i++;
            tick();
        end
        idle();
        repeat (6) tick();
        #2;
        chk("cont_stall_cycles", stalls, 1);
        chk("cont_ex_done", ex_i, 10);
        chk("cont_ld_done", ld_i, 4);
        chk("cont_busy_clear", rs2_busy_o, 0);
        tick();

        // Same-edge set/clear on x9
        rd_addr_i = 5'd9;
        issue_valid_i = 1'b1; issue_waddr_i = 5'd9;
        tick();
        idle();
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'h99;
`ifdef WB_LSU_BYPASS_EN
        issue_valid_i = 1'b1; issue_waddr_i = 5'd9;
        tick();
        idle();
`else
        tick();
        idle();
        issue_valid_i = 1'b1; issue_waddr_i = 5'd9;
        tick();
        idle();
`endif
        #2;
        chk("se_wen", reg_wen_o, 1);
        chk("se_waddr", reg_waddr_o, 9);
        chk("se_rd_busy", rd_busy_o, 1);
        tick();
        lsu_valid_i = 1'b1; lsu_waddr_i = 5'd9; lsu_wdata_i = 32'h98;
        tick();
        idle();
        tick();
        #2;
        chk("se_rd_busy_clr", rd_busy_o, 0);
        tick();

        // Async reset with three queued loads
        rs1_addr_i = 5'd14;
        for (int i = 0; i < 3; i++) begin
            issue_valid_i = 1'b1; issue_waddr_i = 5'(14 + i);
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            ex_wen_i    = 1'b1;
            ex_waddr_i  = 5'(1 + i);
            ex_wdata_i  = 32'hE000 + 32'(i);
            lsu_valid_i = 1'b1;
            lsu_waddr_i = 5'(14 + i);
            lsu_wdata_i = 32'hF000 + 32'(i);
            tick();
        end
        idle();
        ex_wen_i = 1'b1; ex_waddr_i = 5'd4; ex_wdata_i = 32'hE003;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_wen", reg_wen_o, 0);
        chk("ar_busy", rs1_busy_o, 0);
        chk("ar_ready", lsu_ready_o, 0);
        idle();
        tick();
        #1;
        rst = 1'b0;
        wens = 0;
        repeat (5) begin
            tick();
            #2;
            if (reg_wen_o) wens++;
        end
        chk("ar_no_write", wens, 0);
        chk("ar_busy_after", rs1_busy_o, 0);
        chk("ar_ready_after", lsu_ready_o, 1);
        tick();

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
